// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-outstanding memory port between the instruction-fetch
//   requester (IFU, read-only) and the load/store requester (LSU).
//   Exactly one transaction is in flight at a time; requests are only
//   accepted in IDLE, and ties between the requesters are broken round-robin.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no transaction; grant one requester combinationally
//   ISSUE | drive the latched request downstream until mem_req_ready
//   WAIT  | accept one downstream response, latch rdata/err
//   RESP  | present the response to the owner until its resp_ready
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   ifu_req_* / ifu_resp_*           IFU read request / response channels
//   lsu_req_* / lsu_resp_*           LSU read/write request / response channels
//   mem_req_* / mem_resp_*           downstream memory/bus bridge channels

module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_resp_rdata,
  output logic                  ifu_resp_err,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [STRB_WIDTH-1:0] lsu_req_wstrb,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
  output logic                  lsu_resp_err,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [STRB_WIDTH-1:0] mem_req_wstrb,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  input  logic                  mem_resp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t                  state_q,      state_d;
  logic                    owner_q,      owner_d;
  logic                    last_grant_q, last_grant_d;
  logic                    req_wen_q,    req_wen_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q,   req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q,  req_wdata_d;
  logic [STRB_WIDTH-1:0]   req_wstrb_q,  req_wstrb_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q,   resp_err_d;

  logic gnt_ifu;
  logic gnt_lsu;
  logic resp_fire;

  // Grants are combinational in IDLE. They are also qualified with rst_n so
  // that the ready outputs drop immediately when reset is asserted, even
  // though the state register already reads IDLE.
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      // On a tie the requester that did not win last time is granted.
      if (ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU))) begin
        gnt_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        gnt_lsu = 1'b1;
      end
    end
  end

  assign resp_fire = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_wen_d    = req_wen_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (gnt_ifu) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          req_wen_d    = 1'b0;
          req_addr_d   = ifu_req_addr;
          req_wdata_d  = '0;
          req_wstrb_d  = '0;
          state_d      = ISSUE;
        end else if (gnt_lsu) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          req_wen_d    = lsu_req_wen;
          req_addr_d   = lsu_req_addr;
          req_wdata_d  = lsu_req_wdata;
          req_wstrb_d  = lsu_req_wstrb;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          // Stores return zero data regardless of what the bus drives.
          resp_rdata_d = req_wen_q ? '0 : mem_resp_rdata;
          resp_err_d   = mem_resp_err;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      req_wen_q    <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wstrb_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_wen_q    <= req_wen_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wstrb_q  <= req_wstrb_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign ifu_req_ready  = gnt_ifu;
  assign lsu_req_ready  = gnt_lsu;

  // Request fields come straight from registers, so they are stable for the
  // whole ISSUE phase regardless of what the requesters do meanwhile.
  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_req_wen    = req_wen_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_wdata  = req_wdata_q;
  assign mem_req_wstrb  = req_wstrb_q;
  assign mem_resp_ready = (state_q == WAIT);

  assign ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
  assign ifu_resp_rdata = resp_rdata_q;
  assign ifu_resp_err   = resp_err_q;
  assign lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
  assign lsu_resp_rdata = resp_rdata_q;
  assign lsu_resp_err   = resp_err_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-outstanding memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).
- Sits between the IF/EX stages and the memory/bus bridge.
- Each requester sees its own valid/ready request and response channels.
- The block sequences exactly one transaction at a time through a 4-state FSM, with round-robin arbitration.

Parameters:
- ADDR_WIDTH, 32, address width (matches the package ADDR_WIDTH).
- DATA_WIDTH, 32, data width (matches the package DATA_WIDTH).
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ifu_req_valid  in  1  IFU read request valid.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_WIDTH  IFU fetch address (pc).
- ifu_resp_valid  out  1  IFU response valid.
- ifu_resp_ready  in  1  IFU accepts the response.
- ifu_resp_rdata  out  DATA_WIDTH  fetched instruction word.
- ifu_resp_err  out  1  bus error for the fetch.
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_addr  in  ADDR_WIDTH  LSU address.
- lsu_req_wdata  in  DATA_WIDTH  store data.
- lsu_req_wstrb  in  STRB_WIDTH  store byte enables.
- lsu_resp_valid  out  1  LSU response valid.
- lsu_resp_ready  in  1  LSU accepts the response.
- lsu_resp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- lsu_resp_err  out  1  bus error.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts the request.
- mem_req_wen  out  1  downstream write enable.
- mem_req_addr  out  ADDR_WIDTH  downstream address.
- mem_req_wdata  out  DATA_WIDTH  downstream write data.
- mem_req_wstrb  out  STRB_WIDTH  downstream strobes.
- mem_resp_valid  in  1  downstream response valid.
- mem_resp_ready  out  1  arbiter accepts the downstream response.
- mem_resp_rdata  in  DATA_WIDTH  downstream read data.
- mem_resp_err  in  1  downstream error.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Registers: state, owner (0 = IFU, 1 = LSU), last_grant, request registers, response registers.
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=LSU (so the IFU wins the first tie).
  - All request/response registers are 0.
  - Outputs: every *_valid and *_ready is 0; mem_req_* are 0; resp rdata/err are 0.
  - Reset mid-transaction drops the transaction silently; no response is ever delivered for it.
- IDLE:
  - ifu_req_ready/lsu_req_ready are combinational grants; at most one is 1.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - On fire, latch addr/wen/wdata/wstrb, set owner and last_grant, go to ISSUE.
  - For an IFU grant: wen=0, wstrb=0, wdata=0.
- ISSUE:
  - mem_req_valid=1 and mem_req_* are driven from registers and held stable until mem_req_ready.
  - On fire, go to WAIT.
- WAIT:
  - mem_resp_ready=1.
  - On mem_resp_valid, latch rdata (forced to 0 when wen=1) and err, then go to RESP.
  - mem_resp_valid seen in ISSUE or IDLE is ignored (mem_resp_ready=0 there).
- RESP:
  - The owner's resp_valid=1; the other requester's resp_valid=0.
  - On the owner's resp_ready, go to IDLE.
  - Data/err stay stable while valid and unaccepted.
- Requests are never accepted outside IDLE; both req_ready are 0 in ISSUE/WAIT/RESP.
- Minimum latency, with ready/valid all high: req fire at cycle N, then mem_req fire N+1, mem_resp N+2, requester resp N+3, next req accept N+4.
- No internal timeout. A hung downstream holds WAIT indefinitely.
- Addresses pass through unmodified; no alignment check.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 asserted mid-cycle.
  - Required: all valid/ready outputs are 0 immediately (asynchronously).
  - Then, after release with lsu_req_valid=1 from the first cycle: lsu_req_ready=1 in that first cycle.
- IFU read:
  - Stimulus: ifu addr=0x8000_0000; mem ready immediately; rdata=0x0010_0093.
  - Required: mem_req_valid at cycle+1 with wen=0; ifu_resp_valid at cycle+3 with rdata=0x0010_0093 and err=0; lsu_resp_valid stays 0.
- LSU store:
  - Stimulus: addr=0x8000_0104, wdata=0xDEAD_BEEF, wstrb=0b0011, wen=1.
  - Required: mem_req carries the same fields; lsu_resp_rdata=0.
- Simultaneous requests, both held valid for 3 transactions:
  - Required: grants IFU, LSU, IFU (round-robin from reset).
- Backpressure:
  - Stimulus: mem_req_ready low for 4 cycles, then mem_resp_valid delayed 5 cycles, then ifu_resp_ready low for 3 cycles.
  - Required: mem_req_* stable throughout ISSUE, resp rdata stable, no new grant until resp fire.
- Error and reset abort:
  - Stimulus: mem_resp_err=1.
  - Required: lsu_resp_err=1.
  - Stimulus: a reset pulse while in WAIT.
  - Required: state IDLE, no response delivered; a stale mem_resp_valid afterwards is ignored (mem_resp_ready=0).
